fp_result_buffer: RTL and testbench

Buffers results from `floating_point_divider`, which has no backpressure, so that downstream consumers can apply valid/ready flow control. Each accepted result is classified (zero, subnormal, normal, infinity, NaN) into saturating statistics counters. Drops caused by a full buffer raise a sticky overflow flag. It sits directly downstream of the divider and takes the divider's `fp_o`/`valid_o` unchanged.

---
 rtl/fp_pkg.sv | 36 +++
 rtl/sync_fifo_fwft.sv | 55 +++++
 rtl/fp_result_buffer.sv | 94 +++++++++
 tb/tb_fp_result_buffer.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Floating-point helpers shared by the result buffer and the divider bench's golden model.
// Holds the result classification enum and a width-generic classifier.
package fp_pkg;

  typedef enum logic [2:0] {
    FP_ZERO,
    FP_SUBNORMAL,
    FP_NORMAL,
    FP_INF,
    FP_NAN
  } fp_class_e;

  localparam int FP_EXP_MAX_W  = 32;
  localparam int FP_FRAC_MAX_W = 128;

  // Callers zero-extend their fields and pass their real exponent width.
  function automatic fp_class_e fp_classify(
    input logic [FP_EXP_MAX_W-1:0]  exp,
    input logic [FP_FRAC_MAX_W-1:0] frac,
    input int                       exp_w
  );
    logic [FP_EXP_MAX_W-1:0] ones;
    ones = '0;
    for (int i = 0; i < FP_EXP_MAX_W; i++) begin
      ones[i] = (i < exp_w);
    end
    if (exp == ones) begin
      return (frac != '0) ? FP_NAN : FP_INF;
    end
    if (exp == '0) begin
      return (frac == '0) ? FP_ZERO : FP_SUBNORMAL;
    end
    return FP_NORMAL;
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word fall-through synchronous FIFO with wrap-bit pointers.
// A write is accepted when there is room, or when the head leaves in the same cycle.
module sync_fifo_fwft #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             wr_req_i,
  output logic             wr_acc_o,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             rd_valid_o,
  input  logic             rd_ready_i,
  output logic [AW:0]      level_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             full, empty, push, pop;

  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    pop      = !empty && rd_ready_i && !rst_i;
    push     = wr_req_i && (!full || pop) && !rst_i;
    wr_ptr_d = push ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is never cleared; an empty FIFO masks it at the output instead.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
    end
  end

  assign wr_acc_o   = push;
  assign rd_valid_o = !empty;
  assign rd_data_o  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  assign level_o    = wr_ptr_q - rd_ptr_q;

endmodule

// File: rtl/fp_result_buffer.sv
// Elastic buffer behind the divider: adds valid/ready flow control, classifies
// accepted results into saturating counters and flags drops with a sticky overflow.
module fp_result_buffer
  import fp_pkg::*;
#(
  parameter  int EXP_WIDTH  = 8,
  parameter  int FRAC_WIDTH = 23,
  parameter  int DEPTH      = 8,
  parameter  int CNT_WIDTH  = 16,
  localparam int W          = 1 + EXP_WIDTH + FRAC_WIDTH,
  localparam int LW         = $clog2(DEPTH) + 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [W-1:0]         fp_i,
  input  logic                 valid_i,
  output logic [W-1:0]         fp_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [LW-1:0]        level_o,
  output logic                 overflow_o,
  output logic [CNT_WIDTH-1:0] drop_cnt_o,
  output logic [CNT_WIDTH-1:0] nan_cnt_o,
  output logic [CNT_WIDTH-1:0] inf_cnt_o,
  output logic [CNT_WIDTH-1:0] zero_cnt_o,
  output logic [CNT_WIDTH-1:0] subn_cnt_o
);

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] cnt, input logic en);
    return (en && (cnt != '1)) ? cnt + CNT_WIDTH'(1) : cnt;
  endfunction

  logic                 push_acc, drop;
  fp_class_e            cls;
  logic                 overflow_q, overflow_d;
  logic [CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;
  logic [CNT_WIDTH-1:0] nan_cnt_q, nan_cnt_d;
  logic [CNT_WIDTH-1:0] inf_cnt_q, inf_cnt_d;
  logic [CNT_WIDTH-1:0] zero_cnt_q, zero_cnt_d;
  logic [CNT_WIDTH-1:0] subn_cnt_q, subn_cnt_d;

  sync_fifo_fwft #(
    .WIDTH (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .wr_data_i  (fp_i),
    .wr_req_i   (valid_i),
    .wr_acc_o   (push_acc),
    .rd_data_o  (fp_o),
    .rd_valid_o (valid_o),
    .rd_ready_i (ready_i),
    .level_o    (level_o)
  );

  always_comb begin
    cls        = fp_classify(FP_EXP_MAX_W'(fp_i[W-2 -: EXP_WIDTH]),
                             FP_FRAC_MAX_W'(fp_i[FRAC_WIDTH-1:0]), EXP_WIDTH);
    drop       = valid_i && !push_acc && !rst_i;
    overflow_d = overflow_q || drop;
    drop_cnt_d = sat_inc(drop_cnt_q, drop);
    nan_cnt_d  = sat_inc(nan_cnt_q,  push_acc && (cls == FP_NAN));
    inf_cnt_d  = sat_inc(inf_cnt_q,  push_acc && (cls == FP_INF));
    zero_cnt_d = sat_inc(zero_cnt_q, push_acc && (cls == FP_ZERO));
    subn_cnt_d = sat_inc(subn_cnt_q, push_acc && (cls == FP_SUBNORMAL));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
      nan_cnt_q  <= '0;
      inf_cnt_q  <= '0;
      zero_cnt_q <= '0;
      subn_cnt_q <= '0;
    end else begin
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
      nan_cnt_q  <= nan_cnt_d;
      inf_cnt_q  <= inf_cnt_d;
      zero_cnt_q <= zero_cnt_d;
      subn_cnt_q <= subn_cnt_d;
    end
  end

  assign overflow_o = overflow_q;
  assign drop_cnt_o = drop_cnt_q;
  assign nan_cnt_o  = nan_cnt_q;
  assign inf_cnt_o  = inf_cnt_q;
  assign zero_cnt_o = zero_cnt_q;
  assign subn_cnt_o = subn_cnt_q;

endmodule

// File: tb/tb_fp_result_buffer.sv
// Bench for fp_result_buffer: directed scenarios plus random traffic, all checked
// against a queue-based reference model of the buffer and its statistics.
module tb_fp_result_buffer;

  localparam int EW    = 8;
  localparam int FW    = 23;
  localparam int DEPTH = 8;
  localparam int CW    = 2;
  localparam int W     = 1 + EW + FW;
  localparam int LW    = $clog2(DEPTH) + 1;
  localparam int CMAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic [W-1:0]  fp_i = '0;
  logic          valid_i = 1'b0;
  logic          ready_i = 1'b0;
  logic [W-1:0]  fp_o;
  logic          valid_o;
  logic [LW-1:0] level_o;
  logic          overflow_o;
  logic [CW-1:0] drop_cnt_o, nan_cnt_o, inf_cnt_o, zero_cnt_o, subn_cnt_o;

  fp_result_buffer #(
    .EXP_WIDTH  (EW),
    .FRAC_WIDTH (FW),
    .DEPTH      (DEPTH),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .fp_i       (fp_i),
    .valid_i    (valid_i),
    .fp_o       (fp_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .level_o    (level_o),
    .overflow_o (overflow_o),
    .drop_cnt_o (drop_cnt_o),
    .nan_cnt_o  (nan_cnt_o),
    .inf_cnt_o  (inf_cnt_o),
    .zero_cnt_o (zero_cnt_o),
    .subn_cnt_o (subn_cnt_o)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model state
  logic [31:0] mq[$];
  int m_drop, m_nan, m_inf, m_zero, m_subn;
  bit m_ovf;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    else n_pass++;
  endtask

  function automatic int sat(input int c);
    return (c < CMAX) ? c + 1 : c;
  endfunction

  task automatic model_classify(input logic [31:0] x);
    int e, f;
    e = int'((x >> 23) & 32'hFF);
    f = int'(x & 32'h7FFFFF);
    if (e == 255 && f != 0) m_nan = sat(m_nan);
    else if (e == 255)      m_inf = sat(m_inf);
    else if (e == 0 && f == 0) m_zero = sat(m_zero);
    else if (e == 0)        m_subn = sat(m_subn);
  endtask

  task automatic check_all();
    check("valid_o", 64'(valid_o), 64'(mq.size() != 0));
    check("level_o", 64'(level_o), 64'(mq.size()));
    if (mq.size() != 0) check("fp_o", 64'(fp_o), 64'(mq[0]));
    check("overflow_o", 64'(overflow_o), 64'(m_ovf));
    check("drop_cnt", 64'(drop_cnt_o), 64'(m_drop));
    check("nan_cnt",  64'(nan_cnt_o),  64'(m_nan));
    check("inf_cnt",  64'(inf_cnt_o),  64'(m_inf));
    check("zero_cnt", 64'(zero_cnt_o), 64'(m_zero));
    check("subn_cnt", 64'(subn_cnt_o), 64'(m_subn));
  endtask

  // One clock cycle: drive, advance the model, clock, compare.
  task automatic step(input bit v, input logic [31:0] d, input bit r, input bit rs);
    bit do_pop, do_push;
    valid_i = v;
    fp_i    = d;
    ready_i = r;
    rst_i   = rs;
    if (rs) begin
      mq.delete();
      m_drop = 0; m_nan = 0; m_inf = 0; m_zero = 0; m_subn = 0; m_ovf = 0;
    end else begin
      do_pop  = (mq.size() > 0) && r;
      do_push = v && ((mq.size() < DEPTH) || do_pop);
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
        mq.push_back(d);
        model_classify(d);
      end else if (v) begin
        m_drop = sat(m_drop);
        m_ovf  = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  function automatic logic [31:0] rand_fp();
    logic [31:0] s, f;
    s = {$urandom_range(0, 1) == 1, 31'd0};
    f = $urandom & 32'h7FFFFF;
    case ($urandom_range(0, 5))
      0: return s | 32'h7F800000 | (f == 0 ? 32'd1 : f);
      1: return s | 32'h7F800000;
      2: return s;
      3: return s | (f == 0 ? 32'd5 : f);
      default: return s | (32'($urandom_range(1, 254)) << 23) | f;
    endcase
  endfunction

  logic [31:0] cls_vals [5] = '{32'h7FC00000, 32'h7F800000, 32'h80000000, 32'h00000001, 32'h40000000};

  initial begin
    // Reset
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    check("reset fp_o", 64'(fp_o), 64'd0);

    // Single word
    step(1, 32'h3F800000, 0, 0);
    check("single fp_o", 64'(fp_o), 64'h3F800000);
    check("single level", 64'(level_o), 64'd1);
    step(0, 0, 1, 0);
    check("single drained", 64'(level_o), 64'd0);

    // Classes
    step(0, 0, 0, 1);
    for (int i = 0; i < 5; i++) step(1, cls_vals[i], 0, 0);
    check("class nan",  64'(nan_cnt_o),  64'd1);
    check("class inf",  64'(inf_cnt_o),  64'd1);
    check("class zero", 64'(zero_cnt_o), 64'd1);
    check("class subn", 64'(subn_cnt_o), 64'd1);
    for (int i = 0; i < 5; i++) begin
      check("class order", 64'(fp_o), 64'(cls_vals[i]));
      step(0, 0, 1, 0);
    end

    // Overflow
    step(0, 0, 0, 1);
    for (int i = 0; i < DEPTH + 3; i++) step(1, 32'h40000000 + 32'(i), 0, 0);
    check("ovf level", 64'(level_o), 64'(DEPTH));
    check("ovf drops", 64'(drop_cnt_o), 64'd3);
    check("ovf flag",  64'(overflow_o), 64'd1);
    for (int i = 0; i < DEPTH; i++) begin
      check("ovf drain", 64'(fp_o), 64'(32'h40000000 + 32'(i)));
      step(0, 0, 1, 0);
    end
    check("ovf sticky", 64'(overflow_o), 64'd1);

    // Saturation, then reset mid-stream
    for (int i = 0; i < 5; i++) step(1, 32'h7FC00000 + 32'(i), 0, 0);
    check("nan sat", 64'(nan_cnt_o), 64'(CMAX));
    step(1, 32'h7F800000, 1, 1);
    check("rst valid",    64'(valid_o),    64'd0);
    check("rst overflow", 64'(overflow_o), 64'd0);
    check("rst nan",      64'(nan_cnt_o),  64'd0);
    check("rst drop",     64'(drop_cnt_o), 64'd0);

    // Full plus simultaneous pop
    step(0, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++) step(1, 32'h41000000 + 32'(i), 0, 0);
    step(1, 32'h42ABCDEF, 1, 0);
    check("fullpop drop",  64'(drop_cnt_o), 64'd0);
    check("fullpop level", 64'(level_o), 64'(DEPTH));
    for (int i = 0; i < DEPTH - 1; i++) step(0, 0, 1, 0);
    check("fullpop last", 64'(fp_o), 64'h42ABCDEF);
    step(0, 0, 1, 0);

    // Random traffic
    step(0, 0, 0, 1);
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(0, 9) < 7, rand_fp(), $urandom_range(0, 1) == 1,
           $urandom_range(0, 999) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
